// File: rtl/copy_array_restore.sv
// Restores a chunk-split array: copies N[K..9] then N[0..K-1] into M, where K is
// the first index whose bit 3 is clear (10 if every element has bit 3 set).
module copy_array_restore #(
    parameter logic [3:0] LAST = 4'd9
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Ack,
    input  logic [3:0] Ns_of_J,
    output logic [3:0] J,
    output logic [3:0] I,
    output logic       Ms_of_I_Write,
    output logic       Done
);

    typedef enum logic [2:0] {
        INI  = 3'd0,
        SCAN = 3'd1,
        CP0  = 3'd2,
        CP1  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] i_q, i_d;
    logic [3:0] j_q, j_d;
    logic [3:0] k_q, k_d;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of block ordering.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= INI;
            i_q     <= 4'd0;
            j_q     <= 4'd0;
            k_q     <= 4'd0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
        end
    end

    // NOTE: every next-state signal gets a hold default first so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        case (state_q)
            INI: begin
                i_d = 4'd0;
                j_d = 4'd0;
                if (Start) state_d = SCAN;
            end
            SCAN: begin
                if (!Ns_of_J[3]) begin
                    k_d     = j_q;
                    state_d = CP0;
                end else if (j_q == LAST) begin
                    k_d     = 4'd10;
                    j_d     = 4'd0;
                    state_d = CP1;
                end else begin
                    j_d = j_q + 4'd1;
                end
            end
            CP0: begin
                i_d = i_q + 4'd1;
                if (j_q == LAST) begin
                    if (k_q == 4'd0) begin
                        state_d = DONE;
                    end else begin
                        j_d     = 4'd0;
                        state_d = CP1;
                    end
                end else begin
                    j_d = j_q + 4'd1;
                end
            end
            CP1: begin
                i_d = i_q + 4'd1;
                // CP1 is never entered with K=0, so K-1 cannot wrap here.
                if (j_q == (k_q - 4'd1)) state_d = DONE;
                else                     j_d = j_q + 4'd1;
            end
            DONE: begin
                if (Ack) state_d = INI;
            end
            default: state_d = INI;
        endcase
    end

    always_comb begin
        Ms_of_I_Write = 1'b0;
        Done          = 1'b0;
        case (state_q)
            CP0, CP1: Ms_of_I_Write = 1'b1;
            DONE:     Done          = 1'b1;
            default:  ;
        endcase
    end

    assign I = i_q;
    assign J = j_q;

endmodule

// File: tb/tb_copy_array_restore.sv
// Scoreboard bench for copy_array_restore: the driver pushes the expected M image
// and Done cycle per operation; a monitor pops and compares when Done rises.
module tb_copy_array_restore;

    logic       Clk = 1'b0;
    logic       Reset, Start, Ack;
    logic [3:0] Ns_of_J, J, I;
    logic       Ms_of_I_Write, Done;

    copy_array_restore #(.LAST(4'd9)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack), .Ns_of_J(Ns_of_J),
        .J(J), .I(I), .Ms_of_I_Write(Ms_of_I_Write), .Done(Done)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [39:0] m;
        int          done_cycle;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] n_arr [10];
    logic [3:0] m_arr [10];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         cycle    = 0;
    int         wr_count = 0;
    logic [9:0] wr_mask  = '0;
    logic       done_q   = 1'b0;

    assign Ns_of_J = (J <= 4'd9) ? n_arr[J] : 4'h0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        else n_pass++;
    endtask

    // Reference model: K is the first element with bit 3 clear; M is the rotation by K.
    function automatic void model(input logic [39:0] nv, output logic [39:0] mv,
                                  output int k, output int lat);
        k = 10;
        for (int x = 9; x >= 0; x--) if (!nv[4*x+3]) k = x;
        for (int x = 0; x < 10; x++) mv[4*x +: 4] = nv[4*((x + k) % 10) +: 4];
        lat = ((k + 1 > 10) ? 10 : k + 1) + 10;
    endfunction

    // Top-level memory M plus write bookkeeping; values sampled are pre-edge.
    always @(posedge Clk) begin
        cycle  <= cycle + 1;
        done_q <= Done;
        if (Reset || Done) begin
            wr_count <= 0;
            wr_mask  <= '0;
            for (int x = 0; x < 10; x++) m_arr[x] <= 'x;
        end else if (Ms_of_I_Write) begin
            wr_count <= wr_count + 1;
            if (I <= 4'd9) begin
                m_arr[I]   <= Ns_of_J;
                wr_mask[I] <= 1'b1;
            end
        end
    end

    always @(negedge Clk) begin
        if (Ms_of_I_Write) check("ptr_bound", {62'd0, I <= 4'd9, J <= 4'd9}, 64'd3);
    end

    // Monitor: compare on each rising edge of Done.
    always @(posedge Clk) begin
        #1;
        if (Done && !done_q) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                logic [39:0] mv;
                e = exp_q.pop_front();
                for (int x = 0; x < 10; x++) mv[4*x +: 4] = m_arr[x];
                check("m_image", {24'd0, mv}, {24'd0, e.m});
                check("done_cycle", 64'(cycle), 64'(e.done_cycle));
                check("write_count", 64'(wr_count), 64'd10);
                check("write_index_set", {54'd0, wr_mask}, {54'd0, 10'h3FF});
            end
        end
    end

    task automatic start_op(input logic [39:0] nv, output int start_cycle);
        for (int x = 0; x < 10; x++) n_arr[x] = nv[4*x +: 4];
        @(negedge Clk);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        start_cycle = cycle;
    endtask

    // Full operation: push expectation, wait for Done with noise on Start/Ack,
    // optionally hold in DONE, then acknowledge.
    task automatic run_op(input logic [39:0] nv, input int hold);
        logic [39:0] mv;
        int k, lat, sc;
        bit seen;
        exp_t e;
        model(nv, mv, k, lat);
        start_op(nv, sc);
        e.m = mv;
        e.done_cycle = sc + lat;
        exp_q.push_back(e);
        seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            if (Done) begin
                seen = 1;
            end else begin
                Start = 1'($urandom_range(0, 1));
                Ack   = 1'($urandom_range(0, 1));
                @(negedge Clk);
            end
        end
        Start = 1'b0;
        Ack   = 1'b0;
        if (!seen) begin
            check("done_timeout", 64'd0, 64'd1);
            exp_q.delete();
            Reset = 1'b1;
            @(negedge Clk);
            Reset = 1'b0;
        end else begin
            for (int h = 0; h < hold; h++) begin
                Start = 1'(h % 2);
                @(negedge Clk);
                check("hold_done", {63'd0, Done}, 64'd1);
                check("hold_no_write", {63'd0, Ms_of_I_Write}, 64'd0);
                check("hold_i", {60'd0, I}, 64'd10);
                check("hold_j", {60'd0, J}, 64'((k == 0) ? 9 : k - 1));
            end
            Start = 1'b0;
            Ack   = 1'b1;
            @(negedge Clk);
            Ack = 1'b0;
            check("ack_to_ini", {62'd0, Done, Ms_of_I_Write}, 64'd0);
        end
    endtask

    function automatic logic [39:0] pack(input logic [3:0] a0, a1, a2, a3, a4,
                                         a5, a6, a7, a8, a9);
        return {a9, a8, a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    function automatic logic [39:0] rand_n();
        logic [39:0] nv;
        int k;
        int hv, lv;
        k  = $urandom_range(0, 10);
        hv = $urandom_range(8, 11);
        lv = $urandom_range(0, 3);
        for (int x = 0; x < 10; x++) begin
            if (x < k) begin
                nv[4*x +: 4] = 4'(hv);
                hv = (hv + $urandom_range(0, 1) > 15) ? 15 : hv + $urandom_range(0, 1);
            end else begin
                nv[4*x +: 4] = 4'(lv);
                lv = (lv + $urandom_range(0, 1) > 7) ? 7 : lv + $urandom_range(0, 1);
            end
        end
        return nv;
    endfunction

    initial begin
        int sc;
        Reset = 1'b1;
        Start = 1'b1;
        Ack   = 1'b1;
        for (int x = 0; x < 10; x++) n_arr[x] = 4'h0;
        repeat (3) @(negedge Clk);
        check("rst_done", {63'd0, Done}, 64'd0);
        check("rst_write", {63'd0, Ms_of_I_Write}, 64'd0);
        check("rst_i", {60'd0, I}, 64'd0);
        check("rst_j", {60'd0, J}, 64'd0);
        Reset = 1'b0;
        Start = 1'b0;
        Ack   = 1'b0;
        @(negedge Clk);
        check("idle_no_write", {62'd0, Done, Ms_of_I_Write}, 64'd0);

        run_op(pack(4'h9, 4'hA, 4'hC, 4'hF, 4'h1, 4'h2, 4'h5, 4'h6, 4'h7, 4'h8), 0);
        run_op(pack(4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h7, 4'h7), 0);
        run_op(pack(4'h8, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'hF), 0);
        run_op(pack(4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'hF, 4'h0), 0);

        // Reset in CP1 after three CP1 writes (K=4: CP1 writes on edges 12..14).
        start_op(pack(4'h9, 4'hA, 4'hC, 4'hF, 4'h1, 4'h2, 4'h5, 4'h6, 4'h7, 4'h8), sc);
        while (cycle < sc + 14) @(negedge Clk);
        check("pre_reset_in_copy", {63'd0, Ms_of_I_Write}, 64'd1);
        Reset = 1'b1;
        Start = 1'b1;
        Ack   = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        Start = 1'b0;
        Ack   = 1'b0;
        check("mid_rst_i", {60'd0, I}, 64'd0);
        check("mid_rst_j", {60'd0, J}, 64'd0);
        check("mid_rst_outs", {62'd0, Done, Ms_of_I_Write}, 64'd0);
        repeat (2) @(negedge Clk);
        check("mid_rst_idle", {62'd0, Done, Ms_of_I_Write}, 64'd0);
        run_op(pack(4'h9, 4'hA, 4'hC, 4'hF, 4'h1, 4'h2, 4'h5, 4'h6, 4'h7, 4'h8), 0);

        run_op(pack(4'hB, 4'hC, 4'hD, 4'h2, 4'h3, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7), 5);

        for (int t = 0; t < 25; t++) run_op(rand_n(), $urandom_range(0, 2));

        repeat (3) @(negedge Clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
